uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Controller that configures and drains the UART receive path.
- Holds the active Prescale / Parity_EN / Parity_Type driven to the RX FSM, deserializer and parity checker.
- Defers host config writes until the RX FSM is idle, so a frame is never received with mixed settings.
- Buffers received bytes in a small FIFO with a valid/ready consumer handshake, and tracks overrun plus saturating error counters.

Parameters:
- DATA_WIDTH, 8, received word width.
- FIFO_DEPTH, 4, buffered frames; power of 2, at least 2.
- ERR_CNT_W, 8, width of each saturating error counter.
- TO_CYCLES, 1024, idle-timeout threshold in clk cycles (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cfg_wr  in  1  config write strobe.
- cfg_prescale  in  6  requested oversampling; legal values are 8, 16, 32.
- cfg_par_en  in  1  requested parity enable.
- cfg_par_type  in  1  requested parity type (0 = even, 1 = odd).
- rx_busy  in  1  RX FSM is not in IDLE.
- rx_frame_done  in  1  one-cycle pulse at the end of the stop bit, valid or not.
- rx_data_valid  in  1  frame good; qualified by rx_frame_done.
- rx_data  in  DATA_WIDTH  deserialized byte; qualified by rx_frame_done.
- rx_par_err, rx_stop_err, rx_start_glitch  in  1 each  error flags; qualified by rx_frame_done.
- Prescale  out  6  active prescale to the RX datapath.
- Parity_EN, Parity_Type  out  1 each  active parity configuration.
- cfg_pending  out  1  a write is waiting for RX idle.
- cfg_err  out  1  sticky: an illegal prescale was rejected.
- m_data  out  DATA_WIDTH  head of FIFO.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts.
- overrun  out  1  sticky: a good frame was dropped because the FIFO was full.
- par_err_cnt, stop_err_cnt, glitch_cnt  out  ERR_CNT_W each  saturating error counters.
- err_clr  in  1  clears overrun, cfg_err and all counters.

Behaviour:
Reset values:
- Prescale = 8; Parity_EN = 0; Parity_Type = 0.
- FIFO empty, m_valid = 0, m_data = 0.
- All sticky flags and counters = 0.
- Config FSM in CFG_RUN; pending shadow cleared.
- A reset during an ongoing frame discards that frame; the RX FSM is reset by the same rst.

Config FSM states: CFG_RUN, CFG_PEND, CFG_APPLY.
- Legality: cfg_wr with cfg_prescale not in {8, 16, 32} is ignored and sets cfg_err next cycle. State and shadow are unchanged.
- CFG_RUN, legal cfg_wr: latch the shadow. If rx_busy = 0, go to CFG_APPLY; otherwise go to CFG_PEND.
- CFG_PEND: cfg_pending = 1. A legal cfg_wr overwrites the shadow (last write wins). When rx_busy = 0, go to CFG_APPLY.
- CFG_APPLY: one cycle. The active registers load from the shadow; the new values are visible on the cycle after APPLY. Then return to CFG_RUN.
- Apply latency: with rx_busy = 0 at the write, the new config is visible 2 cycles after cfg_wr.
- rx_busy rising during CFG_APPLY: the apply still completes. That frame starts its first sample clock with the old Prescale; this is accepted because the RX FSM samples Prescale only from the start-bit midpoint onward.
- cfg_wr during CFG_APPLY: latch the shadow and go to CFG_PEND.

FIFO:
- Push when rx_frame_done & rx_data_valid.
- Pop when m_valid & m_ready. m_data and m_valid are registered, so a push into an empty FIFO gives m_valid = 1 on the next cycle.
- Full with push and pop in the same cycle: both occur, count unchanged, no overrun.
- Full with push and no pop: the frame is dropped and overrun = 1 next cycle.
- Empty with pop attempted: impossible, because m_valid = 0.
- Pointers wrap modulo FIFO_DEPTH; a count of log2(DEPTH)+1 bits distinguishes full from empty.

Counters:
- On rx_frame_done, each asserted error flag increments its counter. Counters saturate at all-ones.
- Frames with any error are never pushed, regardless of rx_data_valid.

err_clr:
- Clears flags and counters next cycle. When it coincides with an increment, clear wins.
- FIFO contents are unaffected.

Optional Feature:
UART_RX_CTRL_TIMEOUT_EN adds output rx_timeout (1-bit pulse) and a counter.
- The counter counts clk cycles while m_valid = 1 and rx_busy = 0 and no pop occurs.
- It resets on any push, any pop, or rx_busy = 1.
- When it reaches TO_CYCLES-1, rx_timeout pulses for one cycle, and the counter holds until reset by one of the above.
- Without the macro, there is no port, no counter and no parameter use.

Decomposition:
- Package uart_rx_ctrl_pkg holds:
  - the config state enum;
  - legal prescale constants PRESC_8, PRESC_16, PRESC_32;
  - the reset default prescale.
- Sub-module uart_rx_ctrl_fifo: synchronous FIFO with DATA_WIDTH and FIFO_DEPTH parameters, push/pop/full/empty, registered head output. All config and error logic stays in the top module.

Test Plan:
1. Reset, then cfg_wr prescale = 16, par_en = 1 with rx_busy = 0: Prescale = 16 and Parity_EN = 1 exactly 2 cycles later; cfg_pending never asserts.
2. cfg_wr prescale = 32 while rx_busy = 1, then a second cfg_wr prescale = 8 before rx_busy falls: cfg_pending = 1 throughout; Prescale stays 16 until 1 cycle after rx_busy = 0, then becomes 8.
3. cfg_wr prescale = 12: cfg_err = 1; Prescale unchanged; state unchanged.
4. m_ready = 0, five good frames 0x11..0x55 with DEPTH = 4: FIFO holds 0x11..0x44 and overrun = 1. Then with m_ready = 1, data pops in order 0x11, 0x22, 0x33, 0x44.
5. FIFO full and a good frame 0x66 in the same cycle as a pop: no overrun; 0x66 appears last.
6. 300 frames with rx_par_err = 1: par_err_cnt saturates at 255 and none are pushed. Then err_clr gives counters = 0 next cycle.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      CFG_RUN   = 2'd0,
      CFG_PEND  = 2'd1,
      CFG_APPLY = 2'd2
   } cfg_state_t;

   localparam logic [5:0] PRESC_8   = 6'd8;
   localparam logic [5:0] PRESC_16  = 6'd16;
   localparam logic [5:0] PRESC_32  = 6'd32;
   localparam logic [5:0] PRESC_RST = PRESC_8;

   typedef struct packed {
      logic [5:0] prescale;
      logic       par_en;
      logic       par_type;
   } cfg_t;

   localparam cfg_t CFG_RST = '{prescale: PRESC_RST, par_en: 1'b0, par_type: 1'b0};

   function automatic logic presc_legal(input logic [5:0] p);
      return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
   endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous FIFO with a registered head word and head-valid flag.
// Latency: push into empty shows on head_dat/head_vld the next cycle.
// Backpressure: push is dropped when full unless a pop occurs in the same cycle.
module uart_rx_ctrl_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_dat,
   input  logic                  pop,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] head_dat,
   output logic                  head_vld
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         rd_ptr_inc;
   logic [AW:0]           count;
   logic [AW:0]           count_nxt;
   logic                  do_push;
   logic                  do_pop;

   assign full       = (count == (AW+1)'(FIFO_DEPTH));
   assign do_pop     = pop && head_vld;
   assign do_push    = push && (!full || do_pop);
   assign rd_ptr_inc = rd_ptr + 1'b1;

   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + 1'b1;
      else if (!do_push && do_pop)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         head_dat <= '0;
         head_vld <= 1'b0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr_inc;
         count    <= count_nxt;
         head_vld <= (count_nxt != '0);
         // Head is preloaded so it never depends on a read in the same cycle.
         if (do_pop && (count_nxt != '0))
            head_dat <= (count == (AW+1)'(1)) ? push_dat : mem[rd_ptr_inc];
         else if (do_push && (count == '0))
            head_dat <= push_dat;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: deferred config apply, frame FIFO, overrun and error counters.
// Latency: config visible 2 cycles after an idle write; frame on m_valid 1 cycle after push.
// Backpressure: m_valid/m_ready; full FIFO without pop drops the frame (UART_RX_CTRL_TIMEOUT_EN adds rx_timeout).
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int ERR_CNT_W  = 8
`ifdef UART_RX_CTRL_TIMEOUT_EN
   , parameter int TO_CYCLES = 1024
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_wr,
   input  logic [5:0]            cfg_prescale,
   input  logic                  cfg_par_en,
   input  logic                  cfg_par_type,
   input  logic                  rx_busy,
   input  logic                  rx_frame_done,
   input  logic                  rx_data_valid,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_par_err,
   input  logic                  rx_stop_err,
   input  logic                  rx_start_glitch,
   output logic [5:0]            Prescale,
   output logic                  Parity_EN,
   output logic                  Parity_Type,
   output logic                  cfg_pending,
   output logic                  cfg_err,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  overrun,
   output logic [ERR_CNT_W-1:0]  par_err_cnt,
   output logic [ERR_CNT_W-1:0]  stop_err_cnt,
   output logic [ERR_CNT_W-1:0]  glitch_cnt,
   input  logic                  err_clr
`ifdef UART_RX_CTRL_TIMEOUT_EN
   , output logic                rx_timeout
`endif
);

   cfg_state_t cfg_state;
   cfg_t       cfg_shadow;
   cfg_t       cfg_act;
   cfg_t       cfg_req;
   logic       wr_legal;
   logic       frame_err;
   logic       good_frame;
   logic       pop;
   logic       fifo_full;

   assign cfg_req     = '{prescale: cfg_prescale, par_en: cfg_par_en, par_type: cfg_par_type};
   assign wr_legal    = cfg_wr && presc_legal(cfg_prescale);
   assign Prescale    = cfg_act.prescale;
   assign Parity_EN   = cfg_act.par_en;
   assign Parity_Type = cfg_act.par_type;

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_state   <= CFG_RUN;
         cfg_shadow  <= CFG_RST;
         cfg_act     <= CFG_RST;
         cfg_pending <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         if (err_clr)
            cfg_err <= 1'b0;
         else if (cfg_wr && !wr_legal)
            cfg_err <= 1'b1;

         case (cfg_state)
            CFG_RUN: begin
               if (wr_legal) begin
                  cfg_shadow  <= cfg_req;
                  cfg_state   <= rx_busy ? CFG_PEND : CFG_APPLY;
                  cfg_pending <= rx_busy;
               end
            end
            CFG_PEND: begin
               if (wr_legal)
                  cfg_shadow <= cfg_req;
               if (!rx_busy) begin
                  cfg_state   <= CFG_APPLY;
                  cfg_pending <= 1'b0;
               end
            end
            CFG_APPLY: begin
               // Applies even if rx_busy just rose; the RX FSM samples Prescale only from mid start bit.
               cfg_act <= cfg_shadow;
               if (wr_legal) begin
                  cfg_shadow  <= cfg_req;
                  cfg_state   <= CFG_PEND;
                  cfg_pending <= 1'b1;
               end else begin
                  cfg_state   <= CFG_RUN;
                  cfg_pending <= 1'b0;
               end
            end
            default: begin
               cfg_state   <= CFG_RUN;
               cfg_pending <= 1'b0;
            end
         endcase
      end
   end

   assign frame_err  = rx_par_err || rx_stop_err || rx_start_glitch;
   assign good_frame = rx_frame_done && rx_data_valid && !frame_err;
   assign pop        = m_valid && m_ready;

   uart_rx_ctrl_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (good_frame),
      .push_dat (rx_data),
      .pop      (pop),
      .full     (fifo_full),
      .head_dat (m_data),
      .head_vld (m_valid)
   );

   always_ff @(posedge clk) begin
      if (rst || err_clr) begin
         overrun      <= 1'b0;
         par_err_cnt  <= '0;
         stop_err_cnt <= '0;
         glitch_cnt   <= '0;
      end else begin
         if (good_frame && fifo_full && !pop)
            overrun <= 1'b1;
         if (rx_frame_done && rx_par_err && (par_err_cnt != '1))
            par_err_cnt <= par_err_cnt + 1'b1;
         if (rx_frame_done && rx_stop_err && (stop_err_cnt != '1))
            stop_err_cnt <= stop_err_cnt + 1'b1;
         if (rx_frame_done && rx_start_glitch && (glitch_cnt != '1))
            glitch_cnt <= glitch_cnt + 1'b1;
      end
   end

`ifdef UART_RX_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_CYCLES);

   logic [TO_W-1:0] to_cnt;
   logic            to_run;

   assign to_run = m_valid && !rx_busy && !pop && !good_frame;

   always_ff @(posedge clk) begin
      if (rst || !to_run) begin
         to_cnt     <= '0;
         rx_timeout <= 1'b0;
      end else begin
         rx_timeout <= (to_cnt == TO_W'(TO_CYCLES - 2));
         if (to_cnt != TO_W'(TO_CYCLES - 1))
            to_cnt <= to_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: config deferral, FIFO order/overrun, error counters.
// Inputs change 1 ns after posedge; outputs are checked at that same point.
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_wr;
   logic [5:0] cfg_prescale;
   logic       cfg_par_en;
   logic       cfg_par_type;
   logic       rx_busy;
   logic       rx_frame_done;
   logic       rx_data_valid;
   logic [7:0] rx_data;
   logic       rx_par_err;
   logic       rx_stop_err;
   logic       rx_start_glitch;
   logic [5:0] Prescale;
   logic       Parity_EN;
   logic       Parity_Type;
   logic       cfg_pending;
   logic       cfg_err;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic       overrun;
   logic [7:0] par_err_cnt;
   logic [7:0] stop_err_cnt;
   logic [7:0] glitch_cnt;
   logic       err_clr;
`ifdef UART_RX_CTRL_TIMEOUT_EN
   logic       rx_timeout;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_rx_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_wr          (cfg_wr),
      .cfg_prescale    (cfg_prescale),
      .cfg_par_en      (cfg_par_en),
      .cfg_par_type    (cfg_par_type),
      .rx_busy         (rx_busy),
      .rx_frame_done   (rx_frame_done),
      .rx_data_valid   (rx_data_valid),
      .rx_data         (rx_data),
      .rx_par_err      (rx_par_err),
      .rx_stop_err     (rx_stop_err),
      .rx_start_glitch (rx_start_glitch),
      .Prescale        (Prescale),
      .Parity_EN       (Parity_EN),
      .Parity_Type     (Parity_Type),
      .cfg_pending     (cfg_pending),
      .cfg_err         (cfg_err),
      .m_data          (m_data),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .overrun         (overrun),
      .par_err_cnt     (par_err_cnt),
      .stop_err_cnt    (stop_err_cnt),
      .glitch_cnt      (glitch_cnt),
      .err_clr         (err_clr)
`ifdef UART_RX_CTRL_TIMEOUT_EN
      , .rx_timeout    (rx_timeout)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic dv, input logic pe,
                             input logic se, input logic gl);
      rx_frame_done   = 1'b1;
      rx_data         = d;
      rx_data_valid   = dv;
      rx_par_err      = pe;
      rx_stop_err     = se;
      rx_start_glitch = gl;
      tick();
      rx_frame_done   = 1'b0;
      rx_data_valid   = 1'b0;
      rx_par_err      = 1'b0;
      rx_stop_err     = 1'b0;
      rx_start_glitch = 1'b0;
   endtask

   task automatic write_cfg(input logic [5:0] p, input logic pe, input logic pt);
      cfg_wr       = 1'b1;
      cfg_prescale = p;
      cfg_par_en   = pe;
      cfg_par_type = pt;
      tick();
      cfg_wr       = 1'b0;
   endtask

   logic [7:0] exp4 [4];
   logic [7:0] exp5 [4];

   initial begin
      rst = 1'b1; cfg_wr = 1'b0; cfg_prescale = 6'd0; cfg_par_en = 1'b0; cfg_par_type = 1'b0;
      rx_busy = 1'b0; rx_frame_done = 1'b0; rx_data_valid = 1'b0; rx_data = 8'h00;
      rx_par_err = 1'b0; rx_stop_err = 1'b0; rx_start_glitch = 1'b0;
      m_ready = 1'b0; err_clr = 1'b0;
      exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
      exp5 = '{8'hA2, 8'hA3, 8'hA4, 8'h66};
      tick(); tick();
      rst = 1'b0;
      tick();

      check_eq("rst_prescale", 32'(Prescale), 32'd8);
      check_eq("rst_par_en", 32'(Parity_EN), 32'd0);
      check_eq("rst_par_type", 32'(Parity_Type), 32'd0);
      check_eq("rst_m_valid", 32'(m_valid), 32'd0);
      check_eq("rst_m_data", 32'(m_data), 32'd0);
      check_eq("rst_flags", {29'd0, cfg_pending, cfg_err, overrun}, 32'd0);
      check_eq("rst_cnts", {8'd0, par_err_cnt, stop_err_cnt, glitch_cnt}, 32'd0);

      // 1: idle write lands exactly two edges after cfg_wr
      write_cfg(6'd16, 1'b1, 1'b0);
      check_eq("t1_presc_1cyc", 32'(Prescale), 32'd8);
      check_eq("t1_pend_1cyc", 32'(cfg_pending), 32'd0);
      tick();
      check_eq("t1_presc_2cyc", 32'(Prescale), 32'd16);
      check_eq("t1_par_en_2cyc", 32'(Parity_EN), 32'd1);
      check_eq("t1_pend_2cyc", 32'(cfg_pending), 32'd0);

      // 2: writes while busy are deferred; last one wins
      rx_busy = 1'b1;
      write_cfg(6'd32, 1'b1, 1'b1);
      check_eq("t2_pend_a", 32'(cfg_pending), 32'd1);
      check_eq("t2_presc_a", 32'(Prescale), 32'd16);
      tick();
      write_cfg(6'd8, 1'b0, 1'b0);
      check_eq("t2_pend_b", 32'(cfg_pending), 32'd1);
      check_eq("t2_presc_b", 32'(Prescale), 32'd16);
      rx_busy = 1'b0;
      tick();
      check_eq("t2_presc_apply", 32'(Prescale), 32'd16);
      tick();
      check_eq("t2_presc_new", 32'(Prescale), 32'd8);
      check_eq("t2_par_new", {30'd0, Parity_EN, Parity_Type}, 32'd0);
      check_eq("t2_pend_done", 32'(cfg_pending), 32'd0);

      // 3: illegal prescale rejected
      write_cfg(6'd12, 1'b1, 1'b1);
      check_eq("t3_cfg_err", 32'(cfg_err), 32'd1);
      check_eq("t3_pend", 32'(cfg_pending), 32'd0);
      tick(); tick();
      check_eq("t3_presc", 32'(Prescale), 32'd8);
      check_eq("t3_par", {30'd0, Parity_EN, Parity_Type}, 32'd0);

      // 4: overflow with no consumer, then in-order drain
      for (int i = 0; i < 5; i++) begin
         send_frame(8'((i + 1) * 8'h11), 1'b1, 1'b0, 1'b0, 1'b0);
         if (i == 0) begin
            check_eq("t4_first_valid", 32'(m_valid), 32'd1);
            check_eq("t4_first_data", 32'(m_data), 32'h11);
         end
      end
      check_eq("t4_overrun", 32'(overrun), 32'd1);
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("t4_pop%0d_valid", i), 32'(m_valid), 32'd1);
         check_eq($sformatf("t4_pop%0d_data", i), 32'(m_data), 32'(exp4[i]));
         tick();
      end
      m_ready = 1'b0;
      check_eq("t4_empty", 32'(m_valid), 32'd0);

      // 5: full FIFO with simultaneous push and pop
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check_eq("t5_clr_overrun", 32'(overrun), 32'd0);
      check_eq("t5_clr_cfg_err", 32'(cfg_err), 32'd0);
      for (int i = 0; i < 4; i++)
         send_frame(8'hA1 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      m_ready = 1'b1;
      send_frame(8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("t5_no_overrun", 32'(overrun), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("t5_pop%0d_data", i), 32'(m_data), 32'(exp5[i]));
         tick();
      end
      m_ready = 1'b0;
      check_eq("t5_empty", 32'(m_valid), 32'd0);

      // 6: saturating counters, errored frames never buffered, clear wins
      for (int i = 0; i < 300; i++)
         send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("t6_par_sat", 32'(par_err_cnt), 32'd255);
      check_eq("t6_no_push", 32'(m_valid), 32'd0);
      check_eq("t6_stop_zero", 32'(stop_err_cnt), 32'd0);
      for (int i = 0; i < 3; i++)
         send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      check_eq("t6_stop_cnt", 32'(stop_err_cnt), 32'd3);
      check_eq("t6_glitch_cnt", 32'(glitch_cnt), 32'd3);
      check_eq("t6_par_hold", 32'(par_err_cnt), 32'd255);
      err_clr = 1'b1;
      send_frame(8'h77, 1'b1, 1'b1, 1'b1, 1'b1);
      err_clr = 1'b0;
      check_eq("t6_clr_cnts", {8'd0, par_err_cnt, stop_err_cnt, glitch_cnt}, 32'd0);
      check_eq("t6_clr_no_push", 32'(m_valid), 32'd0);
      send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      check_eq("t6_recount", 32'(par_err_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
